// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if
// Groups the serial receive stream and the parallel word result.
//   din        : serial data from the upstream flip-flop Q
//   din_en     : bit-sample enable
//   dout       : last correctly framed data word
//   dout_valid : one-cycle strobe, dout updated this cycle
//   parity_err : one-cycle flag alongside dout_valid on a parity mismatch
//   frame_err  : one-cycle flag, stop bit sampled as 0
//   busy       : frame in progress
// master = stream source / word consumer, slave = the receiver.
interface serial_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic             din;
    logic             din_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             parity_err;
    logic             frame_err;
    logic             busy;

    modport master (
        output din,
        output din_en,
        input  dout,
        input  dout_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  din,
        input  din_en,
        output dout,
        output dout_valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Reassembles framed words from a registered serial stream. A frame is:
// start bit (0), WIDTH data bits LSB first, even-parity bit, stop bit (1).
// The line idles high.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   rx    : serial_frame_rx_if.slave (din, din_en in; dout, dout_valid,
//           parity_err, frame_err, busy out)
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line idle, waiting for an enabled sample of 0 (start bit)
// ST_DATA   | shifting in WIDTH data bits, LSB first
// ST_PARITY | capturing the received parity bit
// ST_STOP   | checking the stop bit, delivering the word or frame error
module serial_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_frame_rx_if.slave rx
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               par_q,   par_d;
    logic [WIDTH-1:0]   dout_q,  dout_d;
    logic               valid_q, valid_d;
    logic               perr_q,  perr_d;
    logic               ferr_q,  ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        dout_d  = dout_q;
        // Status outputs are pulses: they drop on every edge, enabled or not.
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        if (rx.din_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx.din) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
                ST_DATA: begin
                    // Right shift with new bit at MSB: first bit lands in bit 0.
                    shift_d = {rx.din, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = rx.din;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (rx.din) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                        // Parity errors still deliver the word.
                        perr_d  = (^shift_q) ^ par_q;
                    end else begin
                        // A low stop bit is not taken as the next start bit.
                        ferr_d  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rx.dout       = dout_q;
    assign rx.dout_valid = valid_q;
    assign rx.parity_err = perr_q;
    assign rx.frame_err  = ferr_q;
    assign rx.busy       = (state_q != ST_IDLE);

endmodule
